// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
// Direct-mapped, write-back data cache between the CPU byte-wide data port and
// a block-wide (4 bytes) data memory. Hits complete with zero stall; misses
// are sequenced by a small FSM: optional write-back of a dirty victim, block
// refill, then one UPDATE cycle after which the access completes as a hit.
//
// Address split: ADDRESS = {tag[TAG_BITS-1:0], index[INDEX_BITS-1:0], offset[1:0]}
//
// Ports
//   CLK, RESET      clock, synchronous active-high reset
//   READ, WRITE     CPU request strobes (level); WRITE wins if both are high
//   ADDRESS         CPU byte address
//   WRITEDATA       CPU store byte
//   READDATA        CPU load byte (combinational on read hit, holds otherwise)
//   BUSYWAIT        CPU stall (combinational)
//   MEM_READ        registered block read request
//   MEM_WRITE       registered block write request
//   MEM_ADDRESS     block address {tag, index}
//   MEM_WRITEDATA   block to memory, byte0 in [7:0]
//   MEM_READDATA    block from memory
//   MEM_BUSYWAIT    memory busy; a low cycle after the first request cycle
//                   marks completion
//   HIT_COUNT, MISS_COUNT  saturating statistics, only when CACHE_STATS_EN
//
// Optional feature macro: CACHE_STATS_EN
// -----------------------------------------------------------------------------
module dcache_controller #(
    parameter int INDEX_BITS = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    localparam int TAG_BITS   = 6 - INDEX_BITS;
    localparam int NUM_BLOCKS = 2 ** INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        MEM_FETCH  = 2'd2,
        UPDATE     = 2'd3
    } state_t;

    state_t                  state_r;
    logic [NUM_BLOCKS-1:0]   valid_r;
    logic [NUM_BLOCKS-1:0]   dirty_r;
    logic [TAG_BITS-1:0]     tag_arr_r  [NUM_BLOCKS];
    logic [31:0]             data_arr_r [NUM_BLOCKS];

    // Miss target is latched so the transaction can finish even if the CPU
    // withdraws its request and moves the address.
    logic [INDEX_BITS-1:0]   miss_index_r;
    logic [TAG_BITS-1:0]     miss_tag_r;
    // High during the first cycle of a memory request, where MEM_BUSYWAIT is
    // still the stale idle value and must not be taken as completion.
    logic                    first_r;

    logic                    mem_read_r;
    logic                    mem_write_r;
    logic [5:0]              mem_address_r;
    logic [31:0]             mem_writedata_r;
    logic [7:0]              readdata_r;

    logic                    req_s;
    logic                    wr_req_s;
    logic                    rd_req_s;
    logic                    hit_s;
    logic [TAG_BITS-1:0]     cur_tag_s;
    logic [INDEX_BITS-1:0]   cur_index_s;
    logic [1:0]              offset_s;
    logic [31:0]             cur_block_s;
    logic [7:0]              sel_byte_s;
    logic                    fill_s;
    logic                    write_hit_s;

    assign cur_tag_s   = ADDRESS[7 -: TAG_BITS];
    assign cur_index_s = ADDRESS[2 +: INDEX_BITS];
    assign offset_s    = ADDRESS[1:0];

    // Request decode, hit detection, byte select and CPU-side outputs.
    always_comb begin
        req_s       = READ | WRITE;
        wr_req_s    = WRITE;
        rd_req_s    = READ & ~WRITE;
        cur_block_s = data_arr_r[cur_index_s];
        hit_s       = valid_r[cur_index_s] & (tag_arr_r[cur_index_s] == cur_tag_s);
        case (offset_s)
            2'd0:    sel_byte_s = cur_block_s[7:0];
            2'd1:    sel_byte_s = cur_block_s[15:8];
            2'd2:    sel_byte_s = cur_block_s[23:16];
            2'd3:    sel_byte_s = cur_block_s[31:24];
            default: sel_byte_s = 8'h00;
        endcase
        BUSYWAIT = req_s & ((state_r != IDLE) | ~hit_s);
        if (rd_req_s & hit_s) begin
            READDATA = sel_byte_s;
        end else begin
            READDATA = readdata_r;
        end
        fill_s      = ~RESET & (state_r == MEM_FETCH) & ~first_r & ~MEM_BUSYWAIT;
        write_hit_s = ~RESET & (state_r == IDLE) & wr_req_s & hit_s;
    end

    // Tag/data arrays: refill on memory completion, byte write on write hit.
    always_ff @(posedge CLK) begin
        if (fill_s) begin
            tag_arr_r[miss_index_r]  <= miss_tag_r;
            data_arr_r[miss_index_r] <= MEM_READDATA;
        end else if (write_hit_s) begin
            data_arr_r[cur_index_s][{offset_s, 3'b000} +: 8] <= WRITEDATA;
        end
    end

    // Controller FSM with valid/dirty state and registered memory outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r         <= IDLE;
            valid_r         <= '0;
            dirty_r         <= '0;
            miss_index_r    <= '0;
            miss_tag_r      <= '0;
            first_r         <= 1'b0;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_address_r   <= 6'h00;
            mem_writedata_r <= 32'h0000_0000;
            readdata_r      <= 8'h00;
        end else begin
            if (rd_req_s & hit_s) begin
                readdata_r <= sel_byte_s;
            end
            case (state_r)
                IDLE: begin
                    if (req_s & ~hit_s) begin
                        miss_index_r <= cur_index_s;
                        miss_tag_r   <= cur_tag_s;
                        first_r      <= 1'b1;
                        if (dirty_r[cur_index_s]) begin
                            state_r         <= WRITE_BACK;
                            mem_write_r     <= 1'b1;
                            mem_address_r   <= {tag_arr_r[cur_index_s], cur_index_s};
                            mem_writedata_r <= data_arr_r[cur_index_s];
                        end else begin
                            state_r       <= MEM_FETCH;
                            mem_read_r    <= 1'b1;
                            mem_address_r <= {cur_tag_s, cur_index_s};
                        end
                    end else if (wr_req_s & hit_s) begin
                        dirty_r[cur_index_s] <= 1'b1;
                    end
                end
                WRITE_BACK: begin
                    if (first_r) begin
                        first_r <= 1'b0;
                    end else if (~MEM_BUSYWAIT) begin
                        dirty_r[miss_index_r] <= 1'b0;
                        mem_write_r           <= 1'b0;
                        // A withdrawn request skips the refill.
                        if (req_s) begin
                            state_r       <= MEM_FETCH;
                            mem_read_r    <= 1'b1;
                            first_r       <= 1'b1;
                            mem_address_r <= {miss_tag_r, miss_index_r};
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                MEM_FETCH: begin
                    if (first_r) begin
                        first_r <= 1'b0;
                    end else if (~MEM_BUSYWAIT) begin
                        valid_r[miss_index_r] <= 1'b1;
                        dirty_r[miss_index_r] <= 1'b0;
                        mem_read_r            <= 1'b0;
                        state_r               <= UPDATE;
                    end
                end
                UPDATE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_READ      = mem_read_r;
    assign MEM_WRITE     = mem_write_r;
    assign MEM_ADDRESS   = mem_address_r;
    assign MEM_WRITEDATA = mem_writedata_r;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count_r;
    logic [15:0] miss_count_r;
    // Marks an access that already paid for a refill so its final hit is not
    // counted as a hit.
    logic        refill_r;

    // Saturating hit/miss statistics.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_count_r  <= 16'h0000;
            miss_count_r <= 16'h0000;
            refill_r     <= 1'b0;
        end else if (state_r == IDLE) begin
            if (req_s & ~hit_s) begin
                refill_r <= 1'b1;
                if (miss_count_r != 16'hFFFF) begin
                    miss_count_r <= miss_count_r + 16'h0001;
                end
            end else if (req_s & hit_s) begin
                refill_r <= 1'b0;
                if (~refill_r && (hit_count_r != 16'hFFFF)) begin
                    hit_count_r <= hit_count_r + 16'h0001;
                end
            end else begin
                refill_r <= 1'b0;
            end
        end
    end

    assign HIT_COUNT  = hit_count_r;
    assign MISS_COUNT = miss_count_r;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for dcache_controller. A behavioural memory
// (5 busy cycles, then one low completion cycle) and an activity monitor run
// on the falling edge; the CPU stimulus is a linear sequence of accesses with
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_dcache_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
`ifdef CACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    int errors = 0;
    int checks = 0;

    // memory model / monitor state
    logic [31:0] mem [64];
    logic        mem_active;
    int          mem_cnt;
    int          rd_cycles;
    int          wr_cycles;
    int          both_cycles;
    logic [5:0]  last_rd_addr;
    logic [5:0]  last_wr_addr;
    logic [31:0] last_wr_data;

    dcache_controller dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef CACHE_STATS_EN
        ,
        .HIT_COUNT     (HIT_COUNT),
        .MISS_COUNT    (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Behavioural block memory plus request monitor, on the falling edge.
    initial begin : mem_model
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
        mem[5]  = 32'hDDCC_BBAA;
        mem[13] = 32'h4433_2211;
        mem[18] = 32'h8877_6655;
        mem[2]  = 32'hA1B2_C3D4;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = 32'h0000_0000;
        mem_active   = 1'b0;
        mem_cnt      = 0;
        rd_cycles    = 0;
        wr_cycles    = 0;
        both_cycles  = 0;
        last_rd_addr = 6'h00;
        last_wr_addr = 6'h00;
        last_wr_data = 32'h0000_0000;
        forever begin
            @(negedge CLK);
            MEM_READDATA = 32'h0000_0000;
            if (MEM_READ === 1'b1) begin
                rd_cycles++;
                last_rd_addr = MEM_ADDRESS;
            end
            if (MEM_WRITE === 1'b1) begin
                wr_cycles++;
                last_wr_addr = MEM_ADDRESS;
            end
            if (MEM_READ === 1'b1 && MEM_WRITE === 1'b1) both_cycles++;
            if (RESET === 1'b1) begin
                mem_active   = 1'b0;
                MEM_BUSYWAIT = 1'b0;
            end else if (!mem_active) begin
                if (MEM_READ === 1'b1 || MEM_WRITE === 1'b1) begin
                    mem_active = 1'b1;
                    mem_cnt    = 5;
                end
                MEM_BUSYWAIT = 1'b0;
            end else if (mem_cnt > 0) begin
                MEM_BUSYWAIT = 1'b1;
                mem_cnt--;
            end else begin
                MEM_BUSYWAIT = 1'b0;
                mem_active   = 1'b0;
                if (MEM_WRITE === 1'b1) begin
                    mem[MEM_ADDRESS] = MEM_WRITEDATA;
                    last_wr_data     = MEM_WRITEDATA;
                end else begin
                    MEM_READDATA = mem[MEM_ADDRESS];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one access, wait (bounded) for BUSYWAIT low, sample READDATA,
    // let the completing edge pass, then withdraw the request.
    task automatic do_access(input logic rd, input logic wr, input logic [7:0] addr,
                             input logic [7:0] wd, output int stall, output logic [7:0] rdata);
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
        stall = 0;
        #1;
        while (BUSYWAIT !== 1'b0 && stall < 100) begin
            @(negedge CLK);
            #1;
            stall++;
        end
        rdata = READDATA;
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    initial begin : stimulus
        int         stall;
        logic [7:0] rdata;
        int         rd0;
        int         wr0;

        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_busywait", 32'(BUSYWAIT), 32'h0);
        check("rst_mem_read", 32'(MEM_READ), 32'h0);
        check("rst_mem_write", 32'(MEM_WRITE), 32'h0);
        check("rst_mem_address", 32'(MEM_ADDRESS), 32'h0);
        check("rst_mem_writedata", MEM_WRITEDATA, 32'h0);
        check("rst_readdata", 32'(READDATA), 32'h0);
        RESET = 1'b0;

        // clean read miss at 0x14 (tag 0, index 5)
        rd0 = rd_cycles; wr0 = wr_cycles;
        do_access(1'b1, 1'b0, 8'h14, 8'h00, stall, rdata);
        check("miss14_stall", 32'(stall), 32'd9);
        check("miss14_readdata", 32'(rdata), 32'hAA);
        check("miss14_mem_addr", 32'(last_rd_addr), 32'h05);
        check("miss14_read_cycles", 32'(rd_cycles - rd0), 32'd7);
        check("miss14_no_write", 32'(wr_cycles - wr0), 32'd0);
        check("miss14_mem_read_low", 32'(MEM_READ), 32'h0);

        // read hit, same block
        rd0 = rd_cycles; wr0 = wr_cycles;
        do_access(1'b1, 1'b0, 8'h17, 8'h00, stall, rdata);
        check("hit17_stall", 32'(stall), 32'd0);
        check("hit17_readdata", 32'(rdata), 32'hDD);
        check("hit17_no_read", 32'(rd_cycles - rd0), 32'd0);
        check("hit17_no_write", 32'(wr_cycles - wr0), 32'd0);

        // write hit at 0x15
        do_access(1'b0, 1'b1, 8'h15, 8'h5A, stall, rdata);
        check("whit15_stall", 32'(stall), 32'd0);

        // dirty conflict miss at 0x34 (tag 1, index 5)
        rd0 = rd_cycles; wr0 = wr_cycles;
        do_access(1'b1, 1'b0, 8'h34, 8'h00, stall, rdata);
        check("miss34_stall", 32'(stall), 32'd16);
        check("miss34_readdata", 32'(rdata), 32'h11);
        check("miss34_wb_addr", 32'(last_wr_addr), 32'h05);
        check("miss34_wb_data", last_wr_data, 32'hDDCC5AAA);
        check("miss34_fetch_addr", 32'(last_rd_addr), 32'h0D);
        check("miss34_write_cycles", 32'(wr_cycles - wr0), 32'd7);
        check("miss34_read_cycles", 32'(rd_cycles - rd0), 32'd7);
`ifdef CACHE_STATS_EN
        check("stats_miss", 32'(MISS_COUNT), 32'd2);
        check("stats_hit", 32'(HIT_COUNT), 32'd2);
`endif

        // READ and WRITE together on a clean miss at 0x48: treated as a write
        do_access(1'b1, 1'b1, 8'h48, 8'h77, stall, rdata);
        check("both48_stall", 32'(stall), 32'd9);
        check("both48_readdata_held", 32'(rdata), 32'h11);
        check("both48_fetch_addr", 32'(last_rd_addr), 32'h12);
        do_access(1'b1, 1'b0, 8'h49, 8'h00, stall, rdata);
        check("hit49_stall", 32'(stall), 32'd0);
        check("hit49_readdata", 32'(rdata), 32'h66);
        // evicting index 2 must write back the merged, dirty block
        do_access(1'b1, 1'b0, 8'h08, 8'h00, stall, rdata);
        check("miss08_stall", 32'(stall), 32'd16);
        check("miss08_readdata", 32'(rdata), 32'hD4);
        check("miss08_wb_addr", 32'(last_wr_addr), 32'h12);
        check("miss08_wb_data", last_wr_data, 32'h88776677);
        check("miss08_fetch_addr", 32'(last_rd_addr), 32'h02);

        // reset during MEM_FETCH (0x14 misses: index 5 now holds tag 1)
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h14;
        #1;
        check("fetch_busywait", 32'(BUSYWAIT), 32'h1);
        repeat (3) @(negedge CLK);
        #1;
        check("fetch_mem_read", 32'(MEM_READ), 32'h1);
        check("fetch_mem_addr", 32'(MEM_ADDRESS), 32'h05);
        RESET = 1'b1; READ = 1'b0;
        @(negedge CLK);
        #1;
        check("abort_mem_read", 32'(MEM_READ), 32'h0);
        check("abort_busywait", 32'(BUSYWAIT), 32'h0);
        check("abort_mem_addr", 32'(MEM_ADDRESS), 32'h0);
        RESET = 1'b0;
        rd0 = rd_cycles;
        do_access(1'b1, 1'b0, 8'h14, 8'h00, stall, rdata);
        check("reread14_stall", 32'(stall), 32'd9);
        check("reread14_readdata", 32'(rdata), 32'hAA);
        check("reread14_read_cycles", 32'(rd_cycles - rd0), 32'd7);

`ifdef CACHE_STATS_EN
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h14;
        repeat (65540) @(negedge CLK);
        #1;
        READ = 1'b0;
        check("stats_hit_saturate", 32'(HIT_COUNT), 32'hFFFF);
        check("stats_miss_after_rst", 32'(MISS_COUNT), 32'd1);
`endif

        check("never_read_and_write", 32'(both_cycles), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
